// File: rtl/ft600_tx_fifo_drain_if.sv
// FIFO read port plus FT600 245-mode synchronous write bus, bundled for the drain.
`timescale 1ns/1ps
interface ft600_tx_fifo_drain_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                      fifo_r_en;
  logic [DATA_WIDTH-1:0]     fifo_data;
  logic                      fifo_empty;
  logic                      ft_txe_n;
  logic                      ft_wr_n;
  logic [DATA_WIDTH/8-1:0]   ft_be;
  logic [DATA_WIDTH-1:0]     ft_data;

  // Drain side: reads the FIFO, drives the FT600 bus
  modport master (
    output fifo_r_en, ft_wr_n, ft_be, ft_data,
    input  fifo_data, fifo_empty, ft_txe_n
  );

  // FIFO/FT600 side
  modport slave (
    input  fifo_r_en, ft_wr_n, ft_be, ft_data,
    output fifo_data, fifo_empty, ft_txe_n
  );
endinterface

// File: rtl/ft600_tx_fifo_drain.sv
// Drains a synchronous FIFO onto the FT600 host-bound write bus.
// A 2-entry prefetch buffer hides the FIFO read latency so one beat per clock
// is sustained; bursts are capped at MAX_BURST beats followed by a GAP_CYCLES gap.
`timescale 1ns/1ps
module ft600_tx_fifo_drain #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  ft600_tx_fifo_drain_if.master  bus,
  output logic                   busy,
  output logic [31:0]            beats_sent
);

  // beat_cnt only spans 0..MAX_BURST-1 (it clears on reaching MAX_BURST)
  localparam int unsigned BCW = (MAX_BURST  > 1) ? $clog2(MAX_BURST)  : 1;
  localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BCW-1:0]        r_beat_cnt;
  logic [BCW-1:0]        w_beat_cnt_nxt;
  logic [GCW-1:0]        r_gap_cnt;
  logic [GCW-1:0]        w_gap_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_buf0;      // buffer head
  logic [DATA_WIDTH-1:0] r_buf1;      // second entry
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic [31:0]           r_beats_sent;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd;
  logic [2:0]            w_occupancy;

  // Handshake decode: beat acceptance, buffer push and FIFO read issue
  always_comb begin
    w_push      = r_inflight;
    w_pop       = (r_count != 2'd0) && !bus.ft_txe_n && (r_state != ST_GAP);
    w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    // rst gates the strobe so no read is issued while the block is held in reset
    w_rd        = !rst && !bus.fifo_empty && ((w_occupancy < 3'd2) || w_pop);
  end

  assign bus.fifo_r_en = w_rd;
  assign bus.ft_wr_n   = ~w_pop;
  assign bus.ft_be     = w_pop ? '1 : '0;
  assign bus.ft_data   = (r_count != 2'd0) ? r_buf0 : '0;
  assign busy          = (r_count != 2'd0) || r_inflight || (r_state != ST_IDLE);
  assign beats_sent    = r_beats_sent;

  // Prefetch buffer: head shifts forward on pop, returning FIFO word lands at tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      case ({w_push, w_pop})
        2'b01: begin
          r_buf0  <= r_buf1;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) r_buf0 <= bus.fifo_data;
          else                 r_buf1 <= bus.fifo_data;
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          // pop implies count >= 1; with two held the second moves up
          if (r_count == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.fifo_data;
          end else begin
            r_buf0 <= bus.fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Running count of accepted beats, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_beats_sent <= '0;
    else if (w_pop) r_beats_sent <= r_beats_sent + 32'd1;
  end

  // Burst FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  // Burst FSM next state: count beats toward MAX_BURST, then hold off for the gap
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        // beat_cnt persists across IDLE so a paused burst still counts toward the cap
        if (w_pop) begin
          if (r_beat_cnt == BURST_LAST) begin
            w_state_nxt    = ST_GAP;
            w_beat_cnt_nxt = '0;
            w_gap_cnt_nxt  = '0;
          end else begin
            w_state_nxt    = ST_BURST;
            w_beat_cnt_nxt = r_beat_cnt + BCW'(1);
          end
        end
      end
      ST_BURST: begin
        if (w_pop) begin
          if (r_beat_cnt == BURST_LAST) begin
            w_state_nxt    = ST_GAP;
            w_beat_cnt_nxt = '0;
            w_gap_cnt_nxt  = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + BCW'(1);
          end
        end else if ((r_count == 2'd0) && !r_inflight && bus.fifo_empty) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GCW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The read-issue rule must never let a returning word meet a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == 2'd2)))
    else $error("prefetch buffer overflow");

endmodule

// File: tb/tb_ft600_tx_fifo_drain.sv
// Bench for ft600_tx_fifo_drain: two instances (long burst and MAX_BURST=4),
// each fed by a queue-backed FIFO model; a negedge monitor scores every beat.
`timescale 1ns/1ps
module tb_ft600_tx_fifo_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy_a, busy_b;
  logic [31:0] bs_a, bs_b;

  always #5 clk = ~clk;

  ft600_tx_fifo_drain_if #(.DATA_WIDTH(16)) ifa ();
  ft600_tx_fifo_drain_if #(.DATA_WIDTH(16)) ifb ();

  ft600_tx_fifo_drain #(.DATA_WIDTH(16), .MAX_BURST(256), .GAP_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .beats_sent(bs_a));

  ft600_tx_fifo_drain #(.DATA_WIDTH(16), .MAX_BURST(4), .GAP_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .beats_sent(bs_b));

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int          cyc    = 0;

  logic [15:0] fq_a[$], fq_b[$];     // FIFO contents
  logic [15:0] exp_a[$], exp_b[$];   // scoreboard: expected beat order
  int          beat_cyc_a[$], beat_cyc_b[$];
  int          rd_cyc_a[$];

  int rel_t4[10] = '{2, 3, 4, 5, 8, 9, 10, 11, 14, 15};
  int rel_t5[6]  = '{2, 3, 4, 8, 9, 10};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // FIFO models (1-cycle read latency) and cycle counter
  always @(posedge clk) begin
    if (ifa.fifo_r_en && !ifa.fifo_empty) begin
      rd_cyc_a.push_back(cyc);
      ifa.fifo_data <= fq_a.pop_front();
    end
    ifa.fifo_empty <= (fq_a.size() == 0);
    if (ifb.fifo_r_en && !ifb.fifo_empty) ifb.fifo_data <= fq_b.pop_front();
    ifb.fifo_empty <= (fq_b.size() == 0);
    cyc <= cyc + 1;
  end

  // Monitor A
  always @(negedge clk) begin
    if (!rst && ifa.ft_wr_n == 1'b0) begin
      beat_cyc_a.push_back(cyc);
      check("a_be", {30'd0, ifa.ft_be}, 32'h3);
      if (exp_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_extra_beat: got data 0x%0h with no beat expected", ifa.ft_data);
      end else check("a_data", {16'd0, ifa.ft_data}, {16'd0, exp_a.pop_front()});
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!rst && ifb.ft_wr_n == 1'b0) begin
      beat_cyc_b.push_back(cyc);
      check("b_be", {30'd0, ifb.ft_be}, 32'h3);
      if (exp_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_extra_beat: got data 0x%0h with no beat expected", ifb.ft_data);
      end else check("b_data", {16'd0, ifb.ft_data}, {16'd0, exp_b.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq_a.push_back(base + 16'(i));
      exp_a.push_back(base + 16'(i));
    end
  endtask

  task automatic load_b(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq_b.push_back(base + 16'(i));
      exp_b.push_back(base + 16'(i));
    end
  endtask

  task automatic wait_idle(input string name, input bit use_b, input int lim);
    int k = 0;
    while (k < lim && (use_b ? (busy_b || exp_b.size() != 0 || fq_b.size() != 0)
                             : (busy_a || exp_a.size() != 0 || fq_a.size() != 0))) begin
      tick();
      k++;
    end
    check({name, "_done"}, {31'd0, (k < lim)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, base, n, last;
    rst = 1'b1;
    ifa.ft_txe_n = 1'b0;
    ifb.ft_txe_n = 1'b0;

    // T1: reset with a word waiting, then first-word latency
    load_a(16'h1111, 1);
    repeat (3) tick();
    check("t1_rst_wr_n", {31'd0, ifa.ft_wr_n}, 32'd1);
    check("t1_rst_be", {30'd0, ifa.ft_be}, 32'd0);
    check("t1_rst_r_en", {31'd0, ifa.fifo_r_en}, 32'd0);
    check("t1_rst_data", {16'd0, ifa.ft_data}, 32'd0);
    check("t1_rst_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    #1;
    check("t1_r_en_c0", {31'd0, ifa.fifo_r_en}, 32'd1);
    tick();
    check("t1_wr_n_c1", {31'd0, ifa.ft_wr_n}, 32'd1);
    tick();
    check("t1_wr_n_c2", {31'd0, ifa.ft_wr_n}, 32'd0);
    check("t1_data_c2", {16'd0, ifa.ft_data}, 32'h1111);
    check("t1_be_c2", {30'd0, ifa.ft_be}, 32'h3);
    tick();
    check("t1_beats", bs_a, 32'd1);
    wait_idle("t1", 1'b0, 20);

    // T2: 10 back-to-back beats
    beat_cyc_a.delete();
    load_a(16'hA000, 10);
    t0 = cyc;
    wait_idle("t2", 1'b0, 60);
    check("t2_nbeats", beat_cyc_a.size(), 32'd10);
    if (beat_cyc_a.size() == 10) begin
      check("t2_first_lat", beat_cyc_a[0], t0 + 3);
      check("t2_no_bubble", beat_cyc_a[9] - beat_cyc_a[0], 32'd9);
      last = beat_cyc_a[9];
      check("t2_busy_fall", cyc, last + 2);
    end
    check("t2_beats", bs_a, 32'd11);

    // T3: backpressure during relative cycles 4..7
    beat_cyc_a.delete();
    rd_cyc_a.delete();
    load_a(16'hA000, 10);
    base = cyc + 1;
    while (cyc < base + 4) tick();
    ifa.ft_txe_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_hold_data", {16'd0, ifa.ft_data}, 32'hA002);
      tick();
    end
    ifa.ft_txe_n = 1'b0;
    wait_idle("t3", 1'b0, 60);
    n = 0;
    foreach (rd_cyc_a[i]) if (rd_cyc_a[i] >= base + 4 && rd_cyc_a[i] <= base + 7) n++;
    check("t3_stall_reads_le2", {31'd0, (n <= 2)}, 32'd1);
    check("t3_nbeats", beat_cyc_a.size(), 32'd10);
    if (beat_cyc_a.size() == 10) begin
      check("t3_beat2_cyc", beat_cyc_a[1] - base, 32'd3);
      check("t3_resume_cyc", beat_cyc_a[2] - base, 32'd8);
      check("t3_last_cyc", beat_cyc_a[9] - base, 32'd15);
    end
    check("t3_beats", bs_a, 32'd21);

    // T4: MAX_BURST=4, GAP_CYCLES=2 -> 4, gap 2, 4, gap 2, 2
    beat_cyc_b.delete();
    load_b(16'hC000, 10);
    base = cyc + 1;
    wait_idle("t4", 1'b1, 80);
    check("t4_nbeats", beat_cyc_b.size(), 32'd10);
    if (beat_cyc_b.size() == 10)
      for (int i = 0; i < 10; i++) check("t4_beat_cyc", beat_cyc_b[i] - base, rel_t4[i]);
    check("t4_beats", bs_b, 32'd10);

    // T5: FIFO runs dry after word 3 of 6 for three cycles
    beat_cyc_a.delete();
    load_a(16'hE000, 3);
    base = cyc + 1;
    while (cyc < base + 5) tick();
    load_a(16'hE003, 3);
    wait_idle("t5", 1'b0, 60);
    check("t5_nbeats", beat_cyc_a.size(), 32'd6);
    if (beat_cyc_a.size() == 6)
      for (int i = 0; i < 6; i++) check("t5_beat_cyc", beat_cyc_a[i] - base, rel_t5[i]);
    check("t5_beats", bs_a, 32'd27);

    // T6: reset while the buffer holds two words
    ifa.ft_txe_n = 1'b1;
    load_a(16'hF000, 5);
    repeat (4) tick();
    check("t6_busy_full", {31'd0, busy_a}, 32'd1);
    ifa.ft_txe_n = 1'b0;
    #1;
    check("t6_wr_n_pre", {31'd0, ifa.ft_wr_n}, 32'd0);
    check("t6_data_pre", {16'd0, ifa.ft_data}, 32'hF000);
    #1;
    rst = 1'b1;
    #1;
    check("t6_wr_n_rst", {31'd0, ifa.ft_wr_n}, 32'd1);
    check("t6_be_rst", {30'd0, ifa.ft_be}, 32'd0);
    check("t6_data_rst", {16'd0, ifa.ft_data}, 32'd0);
    check("t6_beats_rst", bs_a, 32'd0);
    check("t6_r_en_rst", {31'd0, ifa.fifo_r_en}, 32'd0);
    fq_a.delete();
    exp_a.delete();
    repeat (2) tick();
    rst = 1'b0;
    beat_cyc_a.delete();
    load_a(16'hBEEF, 1);
    wait_idle("t6", 1'b0, 20);
    check("t6_nbeats", beat_cyc_a.size(), 32'd1);
    check("t6_beats", bs_a, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
